// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int INSTR_W    = 32;

endpackage

// File: rtl/mips_instr_rom.sv
// Instruction memory: synchronous 1-cycle read, synchronous write.
module mips_instr_rom
  import mips_fetch_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_addr] <= wr_data;
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mips_instr_fetch.sv
// Fetch stage: PC/issue control, 2-entry output FIFO over a
// synchronous instruction memory, valid/ready output.
module mips_instr_fetch
  import mips_fetch_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        pc_out,
  output logic               busy,
  output logic               done
);

  localparam logic [ADDR_W:0] MAX_LEN =
    {1'b1, {ADDR_W{1'b0}}};

  fetch_state_t state;

  logic [ADDR_W:0]    len;
  logic [ADDR_W:0]    issue_cnt;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_idx;

  logic [INSTR_W-1:0] fifo_instr [FIFO_DEPTH];
  logic [ADDR_W-1:0]  fifo_idx   [FIFO_DEPTH];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         fifo_count;

  logic [INSTR_W-1:0] hold_instr;
  logic [ADDR_W-1:0]  hold_idx;
  logic [ADDR_W-1:0]  head_idx;

  logic [INSTR_W-1:0] rom_data;
  logic               idle_like;
  logic               start_go;
  logic               pop;
  logic               push;
  logic               issue;
  logic [2:0]         occ;
  logic               fifo_drains;
  logic               fetch_end;

  assign idle_like   = (state != FETCH);
  assign start_go    = start & idle_like;
  assign instr_valid = (fifo_count != 2'd0);
  assign pop         = instr_valid & instr_ready;
  assign push        = inflight;

  // Slots already promised: buffered entries plus the read in flight.
  assign occ   = {1'b0, fifo_count} + {2'b00, inflight};
  assign issue = (state == FETCH)
               & (issue_cnt < len)
               & (occ < (3'd2 + {2'b00, pop}));

  assign fifo_drains = (fifo_count == 2'd0)
                     | ((fifo_count == 2'd1) & pop);
  assign fetch_end   = (issue_cnt == len)
                     & ~inflight
                     & fifo_drains;

  assign head_idx  = instr_valid ? fifo_idx[rd_ptr] : hold_idx;
  assign instr_out = instr_valid ? fifo_instr[rd_ptr]
                                 : hold_instr;
  assign pc_out    = {{(32-ADDR_W-2){1'b0}}, head_idx, 2'b00};
  assign busy      = (state == FETCH);
  assign done      = (state == DONE);

  mips_instr_rom #(
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clk     (clk),
    .we      (prog_we & idle_like),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_en   (issue),
    .rd_addr (issue_cnt[ADDR_W-1:0]),
    .rd_data (rom_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      len          <= '0;
      issue_cnt    <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      fifo_count   <= 2'd0;
      hold_instr   <= '0;
      hold_idx     <= '0;
    end else if (start_go) begin
      len        <= (prog_len > MAX_LEN) ? MAX_LEN
                                         : prog_len;
      issue_cnt  <= '0;
      inflight   <= 1'b0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      state      <= (prog_len == '0) ? DONE : FETCH;
    end else if (state == FETCH) begin
      inflight <= issue;
      if (issue) begin
        issue_cnt    <= issue_cnt + 1'b1;
        inflight_idx <= issue_cnt[ADDR_W-1:0];
      end
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr     <= ~rd_ptr;
        hold_instr <= fifo_instr[rd_ptr];
        hold_idx   <= fifo_idx[rd_ptr];
      end
      fifo_count <= fifo_count
                  + {1'b0, push}
                  - {1'b0, pop};
      if (fetch_end)
        state <= DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= rom_data;
      fifo_idx[wr_ptr]   <= inflight_idx;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && fifo_count == 2'(FIFO_DEPTH))
  );

endmodule

// File: tb/tb_mips_instr_fetch.sv
// Directed + randomized bench for mips_instr_fetch against
// an array/queue model of program memory and delivery order.
module tb_mips_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  prog_len;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic        busy;
  logic        done;

  logic [31:0] mem_m [256];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mips_instr_fetch #(
    .ADDR_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .prog_len    (prog_len),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_out      (pc_out),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = 8'(a);
    prog_data = d;
    @(negedge clk);
    prog_we   = 1'b0;
    mem_m[a]  = d;
  endtask

  // mode 0: ready high, 1: stall 5 cycles after first
  // valid, 2: 50% random ready.
  task automatic run(input int n_req, input int mode,
                     input bit inject);
    int n, got, cyc, first_v, last_t, done_c;
    logic r, pv, pr;
    logic [31:0] pi, pp;
    n = (n_req > 256) ? 256 : n_req;
    instr_ready = 1'b0;
    start    = 1'b1;
    prog_len = 9'(n_req);
    @(negedge clk);
    start = 1'b0;
    got = 0; cyc = 0; first_v = -1;
    last_t = -1; done_c = -1;
    pv = 1'b0; pr = 1'b0; pi = '0; pp = '0;
    while (cyc < 3000) begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(instr_valid), 32'd1);
        chk("hold_instr", instr_out, pi);
        chk("hold_pc", pc_out, pp);
      end
      if (instr_valid && first_v < 0)
        first_v = cyc;
      if (done) begin
        done_c = cyc;
        break;
      end
      chk("busy", 32'(busy), 32'd1);
      case (mode)
        0: r = 1'b1;
        1: r = (first_v >= 0) && (cyc >= first_v + 5);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (mode == 1 && first_v >= 0 && !r) begin
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_instr", instr_out, mem_m[0]);
      end
      instr_ready = r;
      if (instr_valid && r) begin
        chk("order_instr", instr_out, mem_m[got]);
        chk("order_pc", pc_out, 32'(got * 4));
        if (mode == 0)
          chk("xfer_cycle", 32'(cyc), 32'(got + 2));
        got++;
        last_t = cyc;
      end
      if (inject && cyc == 2) begin
        prog_we   = 1'b1;
        prog_addr = 8'd7;
        prog_data = ~mem_m[7];
        start     = 1'b1;
        prog_len  = 9'd2;
      end
      if (inject && cyc == 3) begin
        prog_we = 1'b0;
        start   = 1'b0;
      end
      pv = instr_valid; pr = r;
      pi = instr_out;  pp = pc_out;
      @(negedge clk);
      cyc++;
    end
    instr_ready = 1'b0;
    chk("done_seen", 32'(done_c >= 0), 32'd1);
    chk("count", 32'(got), 32'(n));
    if (n > 0)
      chk("first_valid", 32'(first_v), 32'd2);
    chk("done_timing", 32'(done_c), 32'(last_t + 1));
    chk("end_valid", 32'(instr_valid), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] prog4 [4];
    prog4[0] = 32'h20010005;
    prog4[1] = 32'h00221820;
    prog4[2] = 32'h34040F0F;
    prog4[3] = 32'h00000000;
    rst_n = 1'b0; start = 1'b0; prog_len = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) load(i, prog4[i]);
    run(4, 0, 1'b0);
    chk("stream_done", 32'(done), 32'd1);
    chk("stream_last_pc", pc_out, 32'd12);

    for (int i = 0; i < 6; i++) load(i, $urandom);
    run(6, 1, 1'b0);

    for (int i = 0; i < 256; i++) load(i, $urandom);
    run(256, 2, 1'b0);
    chk("rand_last_pc", pc_out, 32'h3FC);
    chk("rand_last_instr", instr_out, mem_m[255]);

    run(0, 0, 1'b0);
    chk("zero_done", 32'(done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("zero_valid", 32'(instr_valid), 32'd0);
    end

    run(12, 0, 1'b1);
    run(300, 0, 1'b0);

    instr_ready = 1'b0;
    start = 1'b1;
    prog_len = 9'd8;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    chk("pre_rst_instr", instr_out, mem_m[0]);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_instr", instr_out, 32'd0);
    chk("mid_rst_pc", pc_out, 32'd0);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(4, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
